// File: rtl/muldiv_if.sv
// Decode-side handshake bundle for the multi-cycle multiply/divide unit.
// Carries operation requests, HI/LO moves, hazard stall and results.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             mf_req;
   logic             mthi;
   logic             mtlo;
   logic [WIDTH-1:0] wd;
   logic             stall;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b, mf_req, mthi, mtlo, wd,
      input  stall, busy, done, div_zero, hi, lo
   );

   modport slave (
      input  start, op, a, b, mf_req, mthi, mtlo, wd,
      output stall, busy, done, div_zero, hi, lo
   );
endinterface

// File: rtl/muldiv_seq.sv
// Radix-2 sequential mult/multu/div/divu unit owning the HI/LO registers.
// Fixed schedule: ITERS RUN cycles plus one FIN cycle for sign fix-up.
module muldiv_seq #(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input logic clk,
   input logic rst,
   muldiv_if.slave bus
);
   localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t state, state_nx;

   logic [CW-1:0]      count;
   logic [1:0]         op_q;
   logic               neg_q;
   logic               rneg_q;
   logic               dz_q;
   logic [WIDTH-1:0]   opd_q;
   logic [WIDTH-1:0]   a_q;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               dz_out_q;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign a_neg = ~bus.op[0] & bus.a[WIDTH-1];
   assign b_neg = ~bus.op[0] & bus.b[WIDTH-1];
   assign a_mag = a_neg ? -bus.a : bus.a;
   assign b_mag = b_neg ? -bus.b : bus.b;

   logic [WIDTH:0]     m_sum;
   logic [2*WIDTH-1:0] m_nx;
   logic [WIDTH:0]     d_rem;
   logic [WIDTH:0]     d_diff;
   logic [2*WIDTH-1:0] d_nx;

   assign m_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opd_q};
   assign m_nx  = acc[0] ? {m_sum, acc[WIDTH-1:1]}
                         : {1'b0, acc[2*WIDTH-1:1]};

   // Partial remainder needs one extra bit after the left shift.
   assign d_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign d_diff = d_rem - {1'b0, opd_q};
   assign d_nx   = d_diff[WIDTH]
                 ? {acc[2*WIDTH-2:0], 1'b0}
                 : {d_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign prod = neg_q ? -acc : acc;
   assign quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem  = rneg_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (op_q[1]) begin
         res_hi = dz_q ? a_q : rem;
         res_lo = dz_q ? '1 : quo;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (bus.start) state_nx = RUN;
         RUN:  if (count == CW'(ITERS - 1)) state_nx = FIN;
         FIN:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         opd_q    <= '0;
         a_q      <= '0;
         acc      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dz_out_q <= 1'b0;
      end else begin
         done_q   <= (state == FIN);
         dz_out_q <= (state == FIN) & op_q[1] & dz_q;
         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q   <= bus.op;
                  neg_q  <= a_neg ^ b_neg;
                  rneg_q <= a_neg;
                  dz_q   <= (bus.b == '0);
                  a_q    <= bus.a;
                  count  <= '0;
                  opd_q  <= bus.op[1] ? b_mag : a_mag;
                  acc    <= {{WIDTH{1'b0}}, bus.op[1] ? a_mag : b_mag};
               end else begin
                  if (bus.mthi) hi_q <= bus.wd;
                  if (bus.mtlo) lo_q <= bus.wd;
               end
            end
            RUN: begin
               acc   <= op_q[1] ? d_nx : m_nx;
               count <= count + 1'b1;
            end
            FIN: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state != IDLE);
   assign bus.stall    = bus.busy
                       & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);
   assign bus.done     = done_q;
   assign bus.div_zero = dz_out_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed corner cases plus randomized ops
// checked against an arithmetic model of MIPS mult/div semantics.
module tb_muldiv_seq;
   logic clk;
   logic rst;
   int   total;
   int   passed;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] model(
      input logic [1:0] op, input logic [31:0] a, input logic [31:0] b
   );
      longint sa, sb, q, r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               res = {32'(r), 32'(q)};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives start in the current cycle and returns what is seen
   // 34 cycles later, counting busy/done anomalies on the way.
   task automatic do_op(
      input  logic [1:0]  op,
      input  logic [31:0] a,
      input  logic [31:0] b,
      output logic [31:0] hi,
      output logic [31:0] lo,
      output logic        dn,
      output logic        dz,
      output int          bad
   );
      bad = 0;
      bus.start = 1'b1;
      bus.op = op;
      bus.a = a;
      bus.b = b;
      step();
      bus.start = 1'b0;
      for (int k = 1; k <= 33; k++) begin
         if (bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
         step();
      end
      if (bus.busy !== 1'b0) bad++;
      hi = bus.hi;
      lo = bus.lo;
      dn = bus.done;
      dz = bus.div_zero;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0;
      bus.op = 2'b00;
      bus.a = '0;
      bus.b = '0;
      bus.mf_req = 1'b0;
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      bus.wd = '0;
      step();
      step();
      rst = 1'b0;
      step();
      total++;
      if ({bus.hi, bus.lo} !== 64'h0) begin
         $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
      end else passed++;
      total++;
      if ({bus.busy, bus.stall, bus.done, bus.div_zero} !== 4'b0) begin
         $display("FAIL reset_flags: got %b want 0000",
                  {bus.busy, bus.stall, bus.done, bus.div_zero});
      end else passed++;
   endtask

   task automatic test_multu_basic();
      logic [31:0] hi, lo;
      logic dn, dz;
      int bad;
      do_op(2'b01, 32'd7, 32'd6, hi, lo, dn, dz, bad);
      total++;
      if (bad != 0) $display("FAIL multu_busy: got %0d bad cycles want 0", bad);
      else passed++;
      total++;
      if ({dn, hi, lo} !== {1'b1, 32'h0, 32'h2A}) begin
         $display("FAIL multu_7x6: got %b %h %h want 1 0 2a", dn, hi, lo);
      end else passed++;
      step();
      total++;
      if (bus.done !== 1'b0) $display("FAIL done_pulse: got %b want 0", bus.done);
      else passed++;
   endtask

   task automatic test_directed();
      logic [1:0]  ops [5] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11};
      logic [31:0] as  [5] = '{32'hFFFF_FFFD, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'h8000_0000, 32'd100};
      logic [31:0] bs  [5] = '{32'd5, 32'h8000_0000, 32'd2,
                               32'hFFFF_FFFF, 32'd0};
      logic [63:0] want [5] = '{64'hFFFF_FFFF_FFFF_FFF1,
                                64'h4000_0000_0000_0000,
                                64'hFFFF_FFFF_FFFF_FFFD,
                                64'h0000_0000_8000_0000,
                                64'h0000_0064_FFFF_FFFF};
      logic [31:0] hi, lo;
      logic dn, dz;
      int bad;
      for (int i = 0; i < 5; i++) begin
         do_op(ops[i], as[i], bs[i], hi, lo, dn, dz, bad);
         total++;
         if ({hi, lo} !== want[i] || dn !== 1'b1 || bad != 0) begin
            $display("FAIL directed_%0d: got %h done=%b bad=%0d want %h",
                     i, {hi, lo}, dn, bad, want[i]);
         end else passed++;
         total++;
         if (dz !== (i == 4)) begin
            $display("FAIL div_zero_%0d: got %b want %b", i, dz, i == 4);
         end else passed++;
         step();
      end
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic [63:0] want;
      logic dn, dz;
      int bad, err;
      err = 0;
      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         if (i % 5 == 1) b = 32'($urandom_range(0, 15));
         if (i % 7 == 3) b = 32'h0;
         if (i % 6 == 2) a = 32'($urandom_range(0, 255));
         want = model(op, a, b);
         do_op(op, a, b, hi, lo, dn, dz, bad);
         if ({hi, lo} !== want || dn !== 1'b1 || bad != 0 ||
             dz !== (op[1] && b == 0)) begin
            err++;
            $display("FAIL random_%0d: op=%0d a=%h b=%h got %h dz=%b want %h",
                     i, op, a, b, {hi, lo}, dz, want);
         end
         if (i % 3 == 0) step();
      end
      total++;
      if (err != 0) $display("FAIL random_total: got %0d errors want 0", err);
      else passed++;
   endtask

   task automatic test_hazard();
      logic [31:0] old_hi, old_lo;
      logic [63:0] w1, w2;
      int stall_bad, hold_bad;
      logic want_stall;
      stall_bad = 0;
      hold_bad = 0;
      step();
      old_hi = bus.hi;
      old_lo = bus.lo;
      w1 = model(2'b01, 32'h0001_2345, 32'h0000_1010);
      w2 = model(2'b11, 32'd1000, 32'd7);
      bus.start = 1'b1;
      bus.op = 2'b01;
      bus.a = 32'h0001_2345;
      bus.b = 32'h0000_1010;
      step();
      bus.start = 1'b0;
      bus.op = 2'b11;
      bus.a = 32'd1000;
      bus.b = 32'd7;
      for (int k = 1; k <= 34; k++) begin
         bus.mf_req = (k >= 5);
         bus.start = (k >= 10);
         #1;
         want_stall = (k >= 5 && k <= 33);
         if (bus.stall !== want_stall) stall_bad++;
         if (k <= 33 && {bus.hi, bus.lo} !== {old_hi, old_lo}) hold_bad++;
         if (k < 34) step();
      end
      total++;
      if (stall_bad != 0) $display("FAIL hazard_stall: got %0d bad want 0", stall_bad);
      else passed++;
      total++;
      if (hold_bad != 0) $display("FAIL hazard_hold: got %0d bad want 0", hold_bad);
      else passed++;
      total++;
      if ({bus.done, bus.hi, bus.lo} !== {1'b1, w1}) begin
         $display("FAIL hazard_first: got %b %h want 1 %h",
                  bus.done, {bus.hi, bus.lo}, w1);
      end else passed++;
      step();
      bus.start = 1'b0;
      bus.mf_req = 1'b0;
      total++;
      if (bus.busy !== 1'b1 || {bus.hi, bus.lo} !== w1) begin
         $display("FAIL back_to_back_accept: got busy=%b %h want 1 %h",
                  bus.busy, {bus.hi, bus.lo}, w1);
      end else passed++;
      for (int k = 35; k < 68; k++) step();
      total++;
      if ({bus.done, bus.hi, bus.lo} !== {1'b1, w2}) begin
         $display("FAIL back_to_back_result: got %b %h want 1 %h",
                  bus.done, {bus.hi, bus.lo}, w2);
      end else passed++;
   endtask

   task automatic test_mthi();
      logic [31:0] old_hi;
      step();
      bus.mthi = 1'b1;
      bus.wd = 32'h1234_5678;
      step();
      bus.mthi = 1'b0;
      total++;
      if (bus.hi !== 32'h1234_5678) $display("FAIL mthi: got %h want 12345678", bus.hi);
      else passed++;
      bus.mthi = 1'b1;
      bus.mtlo = 1'b1;
      bus.wd = 32'hCAFE_F00D;
      step();
      bus.mthi = 1'b0;
      bus.mtlo = 1'b0;
      total++;
      if ({bus.hi, bus.lo} !== {2{32'hCAFE_F00D}}) begin
         $display("FAIL mthi_mtlo: got %h want cafef00dcafef00d", {bus.hi, bus.lo});
      end else passed++;
      old_hi = bus.hi;
      bus.mthi = 1'b1;
      bus.wd = 32'hDEAD_BEEF;
      bus.start = 1'b1;
      bus.op = 2'b01;
      bus.a = 32'd2;
      bus.b = 32'd3;
      step();
      bus.mthi = 1'b0;
      bus.start = 1'b0;
      total++;
      if (bus.hi !== old_hi || bus.busy !== 1'b1) begin
         $display("FAIL mthi_with_start: got hi=%h busy=%b want %h 1",
                  bus.hi, bus.busy, old_hi);
      end else passed++;
      for (int k = 2; k <= 34; k++) step();
      total++;
      if ({bus.done, bus.hi, bus.lo} !== {1'b1, 32'h0, 32'd6}) begin
         $display("FAIL mthi_start_result: got %b %h want 1 0000000000000006",
                  bus.done, {bus.hi, bus.lo});
      end else passed++;
   endtask

   task automatic test_mid_reset();
      logic [31:0] hi, lo;
      logic dn, dz;
      int bad;
      step();
      bus.start = 1'b1;
      bus.op = 2'b00;
      bus.a = 32'h0BAD_F00D;
      bus.b = 32'hFFFF_0001;
      step();
      bus.start = 1'b0;
      bus.mf_req = 1'b1;
      for (int k = 2; k <= 10; k++) step();
      rst = 1'b1;
      #1;
      total++;
      if ({bus.busy, bus.stall} !== 2'b00 || {bus.hi, bus.lo} !== 64'h0) begin
         $display("FAIL mid_reset: got busy=%b stall=%b %h want 0 0 0",
                  bus.busy, bus.stall, {bus.hi, bus.lo});
      end else passed++;
      bus.mf_req = 1'b0;
      step();
      rst = 1'b0;
      step();
      do_op(2'b01, 32'd3, 32'd3, hi, lo, dn, dz, bad);
      total++;
      if ({dn, hi, lo} !== {1'b1, 32'h0, 32'd9} || bad != 0) begin
         $display("FAIL post_reset_3x3: got %b %h %h bad=%0d want 1 0 9",
                  dn, hi, lo, bad);
      end else passed++;
   endtask

   initial begin
      total = 0;
      passed = 0;
      test_reset();
      test_multu_basic();
      test_directed();
      test_hazard();
      test_mthi();
      test_random();
      test_mid_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
